// File: rtl/sample_acquisition_az_seq_pkg.sv
// Shared definitions for the auto-zero sample acquisition sequencer:
// state encodings, phase constants, idle azmux default and the monitor bit map.
package sample_acquisition_az_seq_pkg;

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StPrecharge = 3'd1,
      StSample    = 3'd2,
      StWaitAdc   = 3'd3,
      StDone      = 3'd4
   } sa_state_e;

   localparam logic PHASE_HI = 1'b0;
   localparam logic PHASE_LO = 1'b1;

   localparam int unsigned AZMUX_IDLE_DEFAULT = 0;
   localparam int unsigned SAMPLE_COUNT_W     = 16;

   // monitor_o = {state[2:0], az_phase, adc_meas, sw_pc[1:0], meas_complete}
   function automatic logic [7:0] sa_monitor(input logic [2:0] st,
                                             input logic       phase,
                                             input logic       meas,
                                             input logic [1:0] pc,
                                             input logic       complete);
      return {st, phase, meas, pc, complete};
   endfunction

endpackage

// File: rtl/sample_acquisition_az_seq_if.sv
// Register-set / ADC / output-mux signal bundle of the acquisition sequencer.
// master drives the configuration and ADC strobe; slave is the sequencer.
interface sample_acquisition_az_seq_if #(
   parameter int unsigned AZMUX_W    = 4,
   parameter int unsigned NUM_PC     = 2,
   parameter int unsigned CNT_W      = 24,
   parameter int unsigned APERTURE_W = 32
);

   logic                  arm_i;
   logic [CNT_W-1:0]      p_clk_count_precharge;
   logic [APERTURE_W-1:0] p_clk_sample_duration;
   logic [AZMUX_W-1:0]    p_azmux_hi;
   logic [AZMUX_W-1:0]    p_azmux_lo;
   logic [NUM_PC-1:0]     p_pc_sel;
   logic                  p_az_en;
   logic                  adc_valid_i;

   logic [AZMUX_W-1:0]    azmux_o;
   logic [NUM_PC-1:0]     sw_pc_o;
   logic                  adc_meas_o;
   logic                  meas_complete_o;
   logic                  az_phase_o;
   logic [15:0]           sample_count_o;
   logic                  timeout_o;
   logic [2:0]            state_o;
   logic [7:0]            monitor_o;

   modport master (
      output arm_i, p_clk_count_precharge, p_clk_sample_duration, p_azmux_hi, p_azmux_lo,
             p_pc_sel, p_az_en, adc_valid_i,
      input  azmux_o, sw_pc_o, adc_meas_o, meas_complete_o, az_phase_o, sample_count_o,
             timeout_o, state_o, monitor_o
   );

   modport slave (
      input  arm_i, p_clk_count_precharge, p_clk_sample_duration, p_azmux_hi, p_azmux_lo,
             p_pc_sel, p_az_en, adc_valid_i,
      output azmux_o, sw_pc_o, adc_meas_o, meas_complete_o, az_phase_o, sample_count_o,
             timeout_o, state_o, monitor_o
   );

endinterface

// File: rtl/sample_acquisition_az_seq_down_counter.sv
// Loadable down counter; a load of N makes zero_o rise after exactly max(N,1) cycles
// of the owning phase (a zero load is treated as 1, never as 2^Width).
module sample_acquisition_az_seq_down_counter #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             enable_i,
   input  logic [Width-1:0] value_i,
   output logic             zero_o
);

   logic [Width-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= (value_i == '0) ? '0 : value_i - Width'(1);
      end else if (enable_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - Width'(1);
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sample_acquisition_az_seq.sv
// Sequences precharge switches, az mux and the ADC window, alternating HI/LO samples
// when auto-zero is enabled; adds arm/abort, ADC done handshake, timeout and counters.
module sample_acquisition_az_seq
   import sample_acquisition_az_seq_pkg::*;
#(
   parameter int unsigned AZMUX_W      = 4,
   parameter int unsigned NUM_PC       = 2,
   parameter int unsigned CNT_W        = 24,
   parameter int unsigned APERTURE_W   = 32,
   parameter int unsigned TIMEOUT_CLKS = 1000,
   parameter int unsigned AZMUX_IDLE   = AZMUX_IDLE_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   sample_acquisition_az_seq_if.slave bus
);

   localparam int unsigned TimeoutW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [AZMUX_W-1:0] AzmuxIdle = AZMUX_W'(AZMUX_IDLE);

   sa_state_e             state_q;
   logic                  arm_q;
   logic                  phase_q;
   logic                  az_phase_q;
   logic                  adc_meas_q;
   logic                  meas_complete_q;
   logic                  timeout_q;
   logic                  az_en_q;
   logic [AZMUX_W-1:0]    azmux_q;
   logic [AZMUX_W-1:0]    azmux_hi_q;
   logic [AZMUX_W-1:0]    azmux_lo_q;
   logic [NUM_PC-1:0]     sw_pc_q;
   logic [NUM_PC-1:0]     pc_sel_q;
   logic [CNT_W-1:0]      pc_count_q;
   logic [APERTURE_W-1:0] aperture_q;
   logic [15:0]           sample_count_q;

   logic                  arm_rise;
   logic                  abort;
   logic                  next_phase;
   logic [AZMUX_W-1:0]    next_azmux;
   logic                  pc_load, ap_load, to_load;
   logic                  pc_zero, ap_zero, to_zero;
   logic [CNT_W-1:0]      pc_value;

   assign arm_rise   = bus.arm_i & ~arm_q;
   assign abort      = ~bus.arm_i & (state_q inside {StPrecharge, StSample, StWaitAdc});
   assign next_phase = az_en_q ? ~phase_q : PHASE_HI;
   assign next_azmux = (next_phase == PHASE_LO) ? azmux_lo_q : azmux_hi_q;

   // The first precharge loads straight from the register field at the arm edge.
   assign pc_load  = ((state_q == StIdle) && arm_rise) || ((state_q == StDone) && bus.arm_i);
   assign pc_value = (state_q == StIdle) ? bus.p_clk_count_precharge : pc_count_q;
   assign ap_load  = (state_q == StPrecharge) && pc_zero;
   assign to_load  = (state_q == StSample) && ap_zero;

   sample_acquisition_az_seq_down_counter #(.Width(CNT_W)) u_pc_cnt (
      .clk      (clk),
      .reset    (reset),
      .load_i   (pc_load),
      .enable_i (state_q == StPrecharge),
      .value_i  (pc_value),
      .zero_o   (pc_zero)
   );

   sample_acquisition_az_seq_down_counter #(.Width(APERTURE_W)) u_ap_cnt (
      .clk      (clk),
      .reset    (reset),
      .load_i   (ap_load),
      .enable_i (state_q == StSample),
      .value_i  (aperture_q),
      .zero_o   (ap_zero)
   );

   sample_acquisition_az_seq_down_counter #(.Width(TimeoutW)) u_to_cnt (
      .clk      (clk),
      .reset    (reset),
      .load_i   (to_load),
      .enable_i (state_q == StWaitAdc),
      .value_i  (TimeoutW'(TIMEOUT_CLKS)),
      .zero_o   (to_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= StIdle;
         arm_q           <= 1'b0;
         phase_q         <= PHASE_HI;
         az_phase_q      <= PHASE_HI;
         adc_meas_q      <= 1'b0;
         meas_complete_q <= 1'b0;
         timeout_q       <= 1'b0;
         az_en_q         <= 1'b0;
         azmux_q         <= AzmuxIdle;
         azmux_hi_q      <= '0;
         azmux_lo_q      <= '0;
         sw_pc_q         <= '0;
         pc_sel_q        <= '0;
         pc_count_q      <= '0;
         aperture_q      <= '0;
         sample_count_q  <= '0;
      end else begin
         arm_q           <= bus.arm_i;
         meas_complete_q <= 1'b0;
         if (abort) begin
            // Abort beats a coincident adc_valid_i; count, phase and timeout hold.
            state_q    <= StIdle;
            azmux_q    <= AzmuxIdle;
            sw_pc_q    <= '0;
            adc_meas_q <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (arm_rise) begin
                     state_q    <= StPrecharge;
                     pc_count_q <= bus.p_clk_count_precharge;
                     aperture_q <= bus.p_clk_sample_duration;
                     azmux_hi_q <= bus.p_azmux_hi;
                     azmux_lo_q <= bus.p_azmux_lo;
                     pc_sel_q   <= bus.p_pc_sel;
                     az_en_q    <= bus.p_az_en;
                     phase_q    <= PHASE_HI;
                     az_phase_q <= PHASE_HI;
                     timeout_q  <= 1'b0;
                     azmux_q    <= bus.p_azmux_hi;
                     sw_pc_q    <= bus.p_pc_sel;
                  end
               end
               StPrecharge: begin
                  if (pc_zero) begin
                     state_q    <= StSample;
                     sw_pc_q    <= '0;
                     adc_meas_q <= 1'b1;
                  end
               end
               StSample: begin
                  if (ap_zero) begin
                     state_q    <= StWaitAdc;
                     adc_meas_q <= 1'b0;
                  end
               end
               StWaitAdc: begin
                  if (bus.adc_valid_i) begin
                     state_q         <= StDone;
                     meas_complete_q <= 1'b1;
                     sample_count_q  <= sample_count_q + 16'd1;
                     az_phase_q      <= phase_q;
                  end else if (to_zero) begin
                     state_q   <= StIdle;
                     timeout_q <= 1'b1;
                     azmux_q   <= AzmuxIdle;
                  end
               end
               StDone: begin
                  phase_q <= next_phase;
                  if (bus.arm_i) begin
                     state_q    <= StPrecharge;
                     azmux_q    <= next_azmux;
                     sw_pc_q    <= pc_sel_q;
                     az_phase_q <= next_phase;
                  end else begin
                     state_q <= StIdle;
                     azmux_q <= AzmuxIdle;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bus.azmux_o         = azmux_q;
   assign bus.sw_pc_o         = sw_pc_q;
   assign bus.adc_meas_o      = adc_meas_q;
   assign bus.meas_complete_o = meas_complete_q;
   assign bus.az_phase_o      = az_phase_q;
   assign bus.sample_count_o  = sample_count_q;
   assign bus.timeout_o       = timeout_q;
   assign bus.state_o         = state_q;
   assign bus.monitor_o       = sa_monitor(state_q, az_phase_q, adc_meas_q, sw_pc_q[1:0],
                                           meas_complete_q);

endmodule

// File: tb/tb_sample_acquisition_az_seq.sv
// Scoreboard bench for sample_acquisition_az_seq: directed runs push expected
// completions and switch/window run lengths; a monitor pops and compares them.
module tb_sample_acquisition_az_seq;

   localparam int unsigned AzW    = 4;
   localparam int unsigned NumPc  = 2;
   localparam int unsigned CntW   = 24;
   localparam int unsigned ApW    = 32;
   localparam int unsigned ToClks = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sample_acquisition_az_seq_if #(
      .AZMUX_W(AzW), .NUM_PC(NumPc), .CNT_W(CntW), .APERTURE_W(ApW)
   ) bus ();

   sample_acquisition_az_seq #(
      .AZMUX_W(AzW), .NUM_PC(NumPc), .CNT_W(CntW), .APERTURE_W(ApW),
      .TIMEOUT_CLKS(ToClks), .AZMUX_IDLE(0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [3:0]  azmux;
      logic        phase;
      logic [15:0] count;
   } done_exp_t;

   typedef struct {
      int         len;
      logic [1:0] sel;
   } pc_exp_t;

   done_exp_t done_q[$];
   pc_exp_t   pc_q[$];
   int        meas_q[$];

   int n_checks = 0;
   int n_errors = 0;
   bit run_chk = 1'b1;
   int adc_delay = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // kind: 0 meas_complete, 1 adc_meas high, 2 sw_pc nonzero, 3 state WAIT_ADC
   task automatic wait_until(input int kind, input int max_cycles, input string name);
      bit hit = 1'b0;
      for (int i = 0; i < max_cycles && !hit; i++) begin
         @(negedge clk);
         case (kind)
            0:       hit = bus.meas_complete_o;
            1:       hit = bus.adc_meas_o;
            2:       hit = (bus.sw_pc_o != '0);
            default: hit = (bus.state_o == 3'd3);
         endcase
      end
      if (!hit) check({name, "_wait_expired"}, 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic set_cfg(input int pc, input int ap, input logic [3:0] hi, input logic [3:0] lo,
                          input logic [1:0] sel, input logic az);
      bus.p_clk_count_precharge = CntW'(pc);
      bus.p_clk_sample_duration = ApW'(ap);
      bus.p_azmux_hi = hi;
      bus.p_azmux_lo = lo;
      bus.p_pc_sel = sel;
      bus.p_az_en = az;
   endtask

   // Monitor: completions and run lengths against the scoreboard queues
   initial begin
      int         pc_len;
      int         meas_len;
      logic [1:0] pc_last;
      done_exp_t  e;
      pc_exp_t    p;
      int         m;
      pc_len = 0;
      meas_len = 0;
      pc_last = '0;
      forever begin
         @(negedge clk);
         if (bus.meas_complete_o) begin
            if (done_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = done_q.pop_front();
               check("done_azmux", 32'(bus.azmux_o), 32'(e.azmux));
               check("done_phase", 32'(bus.az_phase_o), 32'(e.phase));
               check("done_count", 32'(bus.sample_count_o), 32'(e.count));
            end
         end
         if (bus.sw_pc_o != '0) begin
            pc_len++;
            pc_last = bus.sw_pc_o;
         end else if (pc_len != 0) begin
            if (run_chk) begin
               if (pc_q.size() == 0) begin
                  check("unexpected_pc_run", 32'(pc_len), 32'd0);
               end else begin
                  p = pc_q.pop_front();
                  check("pc_run_len", 32'(pc_len), 32'(p.len));
                  check("pc_run_sel", 32'(pc_last), 32'(p.sel));
               end
            end
            pc_len = 0;
         end
         if (bus.adc_meas_o) begin
            meas_len++;
         end else if (meas_len != 0) begin
            if (run_chk) begin
               if (meas_q.size() == 0) begin
                  check("unexpected_meas_run", 32'(meas_len), 32'd0);
               end else begin
                  m = meas_q.pop_front();
                  check("meas_run_len", 32'(meas_len), 32'(m));
               end
            end
            meas_len = 0;
         end
      end
   end

   // ADC model: answers adc_delay clocks after the window closes; negative = never
   initial begin
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (prev && !bus.adc_meas_o && adc_delay >= 0) begin
            prev = 1'b0;
            if (adc_delay == 0) begin
               bus.adc_valid_i = 1'b1;
            end else begin
               repeat (adc_delay) @(posedge clk);
               #1 bus.adc_valid_i = 1'b1;
            end
            @(posedge clk);
            #1 bus.adc_valid_i = 1'b0;
         end else begin
            prev = bus.adc_meas_o;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.arm_i = 1'b0;
      bus.adc_valid_i = 1'b0;
      set_cfg(0, 0, 4'h0, 4'h0, 2'b00, 1'b0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_state", 32'(bus.state_o), 32'd0);
      check("rst_azmux", 32'(bus.azmux_o), 32'd0);
      check("rst_sw_pc", 32'(bus.sw_pc_o), 32'd0);
      check("rst_adc_meas", 32'(bus.adc_meas_o), 32'd0);
      check("rst_complete", 32'(bus.meas_complete_o), 32'd0);
      check("rst_phase", 32'(bus.az_phase_o), 32'd0);
      check("rst_count", 32'(bus.sample_count_o), 32'd0);
      check("rst_timeout", 32'(bus.timeout_o), 32'd0);
      check("rst_monitor", 32'(bus.monitor_o), 32'd0);

      // Single HI sample: 5-clock precharge, 10-clock aperture
      set_cfg(5, 10, 4'h3, 4'h8, 2'b01, 1'b0);
      pc_q.push_back('{len: 5, sel: 2'b01});
      meas_q.push_back(10);
      done_q.push_back('{azmux: 4'h3, phase: 1'b0, count: 16'd1});
      adc_delay = 3;
      bus.arm_i = 1'b1;
      @(posedge clk);
      #1;
      check("arm_latency_sw_pc", 32'(bus.sw_pc_o), 32'h1);
      check("arm_latency_azmux", 32'(bus.azmux_o), 32'h3);
      check("arm_latency_state", 32'(bus.state_o), 32'd1);
      wait_until(0, 100, "t1_done");
      bus.arm_i = 1'b0;
      @(negedge clk);
      check("t1_count", 32'(bus.sample_count_o), 32'd1);
      check("t1_idle", 32'(bus.state_o), 32'd0);
      check("t1_idle_azmux", 32'(bus.azmux_o), 32'd0);

      // Auto-zero alternation over four samples
      do_reset();
      set_cfg(2, 3, 4'h3, 4'h8, 2'b10, 1'b1);
      adc_delay = 0;
      for (int i = 0; i < 4; i++) begin
         pc_q.push_back('{len: 2, sel: 2'b10});
         meas_q.push_back(3);
         done_q.push_back('{azmux: (i % 2 == 0) ? 4'h3 : 4'h8, phase: 1'(i % 2),
                            count: 16'(i + 1)});
      end
      bus.arm_i = 1'b1;
      for (int i = 0; i < 4; i++) wait_until(0, 100, "t2_done");
      bus.arm_i = 1'b0;
      @(negedge clk);
      check("t2_count", 32'(bus.sample_count_o), 32'd4);

      // Zero precharge and aperture behave as one clock each
      do_reset();
      set_cfg(0, 0, 4'h5, 4'h9, 2'b11, 1'b0);
      for (int i = 0; i < 2; i++) begin
         pc_q.push_back('{len: 1, sel: 2'b11});
         meas_q.push_back(1);
         done_q.push_back('{azmux: 4'h5, phase: 1'b0, count: 16'(i + 1)});
      end
      bus.arm_i = 1'b1;
      for (int i = 0; i < 2; i++) wait_until(0, 50, "t3_done");
      bus.arm_i = 1'b0;
      @(negedge clk);

      // Timeout after 16 clocks in WAIT_ADC, re-arm clears it
      do_reset();
      set_cfg(1, 1, 4'h6, 4'h1, 2'b01, 1'b0);
      pc_q.push_back('{len: 1, sel: 2'b01});
      meas_q.push_back(1);
      adc_delay = -1;
      bus.arm_i = 1'b1;
      wait_until(3, 50, "t4_wait_adc");
      n = 0;
      while (bus.state_o == 3'd3 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("t4_wait_len", 32'(n), 32'd16);
      check("t4_timeout", 32'(bus.timeout_o), 32'd1);
      check("t4_state", 32'(bus.state_o), 32'd0);
      check("t4_azmux", 32'(bus.azmux_o), 32'd0);
      bus.arm_i = 1'b0;
      @(negedge clk);
      check("t4_timeout_sticky", 32'(bus.timeout_o), 32'd1);
      adc_delay = 0;
      pc_q.push_back('{len: 1, sel: 2'b01});
      meas_q.push_back(1);
      done_q.push_back('{azmux: 4'h6, phase: 1'b0, count: 16'd1});
      bus.arm_i = 1'b1;
      @(negedge clk);
      check("t4_rearm_clears", 32'(bus.timeout_o), 32'd0);
      wait_until(0, 50, "t4_done");
      bus.arm_i = 1'b0;
      @(negedge clk);

      // Abort mid-SAMPLE
      do_reset();
      set_cfg(2, 10, 4'h9, 4'h2, 2'b10, 1'b0);
      run_chk = 1'b0;
      bus.arm_i = 1'b1;
      wait_until(1, 50, "t5_sample");
      check("t5_monitor_sample", 32'(bus.monitor_o), 32'h48);
      repeat (3) @(negedge clk);
      bus.arm_i = 1'b0;
      @(negedge clk);
      check("t5_adc_meas", 32'(bus.adc_meas_o), 32'd0);
      check("t5_sw_pc", 32'(bus.sw_pc_o), 32'd0);
      check("t5_azmux", 32'(bus.azmux_o), 32'd0);
      check("t5_state", 32'(bus.state_o), 32'd0);
      repeat (4) @(negedge clk);
      check("t5_count", 32'(bus.sample_count_o), 32'd0);
      run_chk = 1'b1;

      // Count wraps 0xFFFF -> 0
      do_reset();
      force dut.sample_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.sample_count_q;
      @(negedge clk);
      check("t6_forced", 32'(bus.sample_count_o), 32'hFFFF);
      set_cfg(1, 2, 4'h4, 4'h7, 2'b01, 1'b0);
      pc_q.push_back('{len: 1, sel: 2'b01});
      meas_q.push_back(2);
      done_q.push_back('{azmux: 4'h4, phase: 1'b0, count: 16'd0});
      bus.arm_i = 1'b1;
      wait_until(0, 50, "t6_done");
      bus.arm_i = 1'b0;
      @(negedge clk);
      check("t6_wrap", 32'(bus.sample_count_o), 32'd0);

      // Reset during PRECHARGE
      set_cfg(5, 2, 4'hA, 4'h7, 2'b11, 1'b1);
      run_chk = 1'b0;
      bus.arm_i = 1'b1;
      wait_until(2, 20, "t6_precharge");
      reset = 1'b1;
      @(negedge clk);
      check("t6_rst_state", 32'(bus.state_o), 32'd0);
      check("t6_rst_sw_pc", 32'(bus.sw_pc_o), 32'd0);
      check("t6_rst_azmux", 32'(bus.azmux_o), 32'd0);
      check("t6_rst_adc_meas", 32'(bus.adc_meas_o), 32'd0);
      check("t6_rst_monitor", 32'(bus.monitor_o), 32'd0);
      reset = 1'b0;
      bus.arm_i = 1'b0;
      repeat (3) @(negedge clk);
      run_chk = 1'b1;

      check("left_done", 32'(done_q.size()), 32'd0);
      check("left_pc", 32'(pc_q.size()), 32'd0);
      check("left_meas", 32'(meas_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
